// File: rtl/bus_arbiter_n_if.sv
// Bus-controller interface: per-master request/status in, per-master command and
// bus-ownership selects out.
interface bus_arbiter_n_if #(
    parameter int unsigned M = 4,
    parameter int unsigned S = 3
);
    localparam int unsigned MW   = $clog2(M);
    localparam int unsigned ID_W = $clog2(S + 1);

    logic [M*ID_W-1:0] i_id;
    logic [2*M-1:0]    i_com_state;
    logic [2*M-1:0]    o_cmd;
    logic              o_bus_valid;
    logic [MW-1:0]     o_bus_master;
    logic [ID_W-1:0]   o_bus_slave;

    // Controller side.
    modport master (
        input  i_id,
        input  i_com_state,
        output o_cmd,
        output o_bus_valid,
        output o_bus_master,
        output o_bus_slave
    );

    // Bus-master / environment side.
    modport slave (
        output i_id,
        output i_com_state,
        input  o_cmd,
        input  o_bus_valid,
        input  o_bus_master,
        input  o_bus_slave
    );
endinterface

// File: rtl/bus_arbiter_n.sv
// Bus controller granting one of M masters onto one of S slaves: CLEAR/ack handshake,
// fixed-priority or round-robin selection, preemption and timeout-forced split.
module bus_arbiter_n #(
    parameter int unsigned M       = 4,
    parameter int unsigned S       = 3,
    parameter int unsigned MODE    = 0,
    parameter int unsigned PREEMPT = 1,
    parameter int unsigned TIMEOUT = 100
) (
    input  logic            clk,
    input  logic            rstN,
    bus_arbiter_n_if.master bus
);
    localparam int unsigned MW   = $clog2(M);
    localparam int unsigned ID_W = $clog2(S + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CmdStopS = 2'b01;
    localparam logic [1:0] CmdStopP = 2'b10;
    localparam logic [1:0] CmdClear = 2'b11;

    localparam logic [1:0] CsEndCom = 2'b00;
    localparam logic [1:0] CsNak    = 2'b01;
    localparam logic [1:0] CsCom    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StAck,
        StCom,
        StStop,
        StRelease
    } state_e;

    state_e          r_state,      w_state_nxt;
    logic [MW-1:0]   r_winner,     w_winner_nxt;
    logic [ID_W-1:0] r_slave_id,   w_slave_id_nxt;
    logic [MW-1:0]   r_rr_ptr,     w_rr_ptr_nxt;
    logic [TW-1:0]   r_timer,      w_timer_nxt;
    logic [2*M-1:0]  r_cmd,        w_cmd_nxt;
    logic            r_bus_valid,  w_bus_valid_nxt;
    logic [MW-1:0]   r_bus_master, w_bus_master_nxt;
    logic [ID_W-1:0] r_bus_slave,  w_bus_slave_nxt;

    logic [M-1:0]    w_req;
    logic [ID_W-1:0] w_id_slot;
    logic            w_found;
    logic [MW-1:0]   w_sel;
    logic [MW-1:0]   w_scan_idx;
    logic            w_preempt;
    logic [1:0]      w_com;
    logic            w_timer_hit;
    logic [TW-1:0]   w_timer_inc;

    always_comb begin
        w_req     = '0;
        w_id_slot = '0;
        for (int i = 0; i < int'(M); i++) begin
            w_id_slot = bus.i_id[i*ID_W +: ID_W];
            w_req[i]  = (w_id_slot != '0) && (w_id_slot <= ID_W'(S));
        end
    end

    // Scan from the highest offset down so the lowest offset (first in order) wins.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_scan_idx = '0;
        for (int k = int'(M) - 1; k >= 0; k--) begin
            if (MODE == 0) begin
                w_scan_idx = MW'(k);
            end else begin
                w_scan_idx = MW'((int'(r_rr_ptr) + k) % int'(M));
            end
            if (w_req[w_scan_idx]) begin
                w_found = 1'b1;
                w_sel   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_preempt = 1'b0;
        for (int j = 0; j < int'(M); j++) begin
            if (w_req[j] && (MW'(j) < r_winner)) begin
                w_preempt = 1'b1;
            end
        end
    end

    assign w_com       = bus.i_com_state[int'(r_winner)*2 +: 2];
    // Hit on the edge at which the timer would reach TIMEOUT.
    assign w_timer_hit = (r_timer >= TW'(TIMEOUT - 1));
    assign w_timer_inc = (r_timer == TW'(TIMEOUT)) ? r_timer : r_timer + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_winner_nxt     = r_winner;
        w_slave_id_nxt   = r_slave_id;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_timer_nxt      = r_timer;
        w_cmd_nxt        = r_cmd;
        w_bus_valid_nxt  = r_bus_valid;
        w_bus_master_nxt = r_bus_master;
        w_bus_slave_nxt  = r_bus_slave;

        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_winner_nxt   = w_sel;
                    w_slave_id_nxt = bus.i_id[int'(w_sel)*ID_W +: ID_W];
                    w_state_nxt    = StGrant;
                end
            end
            StGrant: begin
                w_cmd_nxt                           = '0;
                w_cmd_nxt[int'(r_winner)*2 +: 2]    = CmdClear;
                w_timer_nxt                         = '0;
                w_state_nxt                         = StAck;
            end
            StAck: begin
                if (w_com == CsCom) begin
                    w_bus_valid_nxt  = 1'b1;
                    w_bus_master_nxt = r_winner;
                    w_bus_slave_nxt  = r_slave_id;
                    w_timer_nxt      = '0;
                    w_state_nxt      = StCom;
                end else if ((w_com == CsNak) || w_timer_hit) begin
                    w_state_nxt = StRelease;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            StCom: begin
                if (w_com == CsEndCom) begin
                    w_state_nxt = StRelease;
                end else if ((PREEMPT != 0) && (MODE == 0) && w_preempt) begin
                    w_cmd_nxt[int'(r_winner)*2 +: 2] = CmdStopP;
                    w_state_nxt                      = StStop;
                end else if (w_timer_hit) begin
                    w_cmd_nxt[int'(r_winner)*2 +: 2] = CmdStopS;
                    w_state_nxt                      = StStop;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            StStop: begin
                if (w_com == CsEndCom) begin
                    w_state_nxt = StRelease;
                end
            end
            StRelease: begin
                w_rr_ptr_nxt = (r_winner == MW'(M - 1)) ? '0 : r_winner + 1'b1;
                w_state_nxt  = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Ownership and commands drop on the edge that enters RELEASE.
        if (w_state_nxt == StRelease) begin
            w_cmd_nxt       = '0;
            w_bus_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= StIdle;
            r_winner     <= '0;
            r_slave_id   <= '0;
            r_rr_ptr     <= '0;
            r_timer      <= '0;
            r_cmd        <= '0;
            r_bus_valid  <= 1'b0;
            r_bus_master <= '0;
            r_bus_slave  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_winner     <= w_winner_nxt;
            r_slave_id   <= w_slave_id_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_timer      <= w_timer_nxt;
            r_cmd        <= w_cmd_nxt;
            r_bus_valid  <= w_bus_valid_nxt;
            r_bus_master <= w_bus_master_nxt;
            r_bus_slave  <= w_bus_slave_nxt;
        end
    end

    assign bus.o_cmd        = r_cmd;
    assign bus.o_bus_valid  = r_bus_valid;
    assign bus.o_bus_master = r_bus_master;
    assign bus.o_bus_slave  = r_bus_slave;
endmodule
